// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | audio_pkg: shared audio-path widths, defaults and rx state enum.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package audio_pkg;

  localparam int AUDIO_DW              = 24;
  localparam int AUDIO_I2S_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    RECEIVE = 2'd2
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge_detect: N-flop synchronizer with registered rising pulse. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_edge_detect
  import audio_pkg::*;
#(
  parameter int SYNC_STAGES = AUDIO_I2S_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  assign level = r_sync[SYNC_STAGES-1];

  // The rise pulse is registered so that the downstream framing logic
  // lands its strobe exactly SYNC_STAGES+2 cycles after the pin edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      rise   <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_rx_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2s_rx_deserializer: I2S receive front end, 24-bit L/R PCM output.  |
// | Optional error counter: define AUDIO_I2S_RX_ERR_CNT_EN.  Rev 1.0    |
// +--------------------------------------------------------------------+
module i2s_rx_deserializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH     = AUDIO_DW,
  parameter int SYNC_STAGES    = AUDIO_I2S_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  s_data,
  output logic                  l_data_stb,
  output logic                  r_data_stb,
  output logic [DATA_WIDTH-1:0] l_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  locked
`ifdef AUDIO_I2S_RX_ERR_CNT_EN
  , output logic                frame_err
  , output logic [7:0]          err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic w_bclk_rise, w_lr, w_sd;
  logic w_bclk_level_unused, w_lr_rise_unused, w_sd_rise_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk(clk), .reset_n(reset_n), .async_in(bclk),
    .level(w_bclk_level_unused), .rise(w_bclk_rise));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk(clk), .reset_n(reset_n), .async_in(lrclk),
    .level(w_lr), .rise(w_lr_rise_unused));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sdata_sync (
    .clk(clk), .reset_n(reset_n), .async_in(s_data),
    .level(w_sd), .rise(w_sd_rise_unused));

  rx_state_e             r_state, n_state;
  logic                  r_prev_lr, n_prev_lr;
  logic                  r_slot_lr, n_slot_lr;
  logic [CNT_W-1:0]      r_bit_cnt, n_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift, n_shift;
  logic [TMO_W-1:0]      r_tmo, n_tmo;
  logic [DATA_WIDTH-1:0] n_l_data, n_r_data;
  logic                  n_l_stb, n_r_stb, n_locked;
  logic                  w_lr_edge, w_timeout, w_err;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_lr_edge = w_bclk_rise && (w_lr != r_prev_lr);
  assign w_timeout = (r_state != IDLE) && !w_bclk_rise &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_word    = {r_shift[DATA_WIDTH-2:0], w_sd};

  always_comb begin
    n_state   = r_state;
    n_prev_lr = w_bclk_rise ? w_lr : r_prev_lr;
    n_slot_lr = r_slot_lr;
    n_bit_cnt = r_bit_cnt;
    n_shift   = r_shift;
    n_tmo     = (r_state == IDLE || w_bclk_rise || w_timeout) ? '0 : r_tmo + TMO_W'(1);
    n_l_data  = l_data;
    n_r_data  = r_data;
    n_l_stb   = 1'b0;
    n_r_stb   = 1'b0;
    n_locked  = locked;
    w_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (enable) n_state = SEEK;
      end
      SEEK: begin
        // Only the start of a left slot (lrclk 1->0) opens a frame.
        if (w_lr_edge && !w_lr) begin
          n_state   = RECEIVE;
          n_bit_cnt = '0;
          n_slot_lr = 1'b0;
        end
      end
      RECEIVE: begin
        if (w_timeout) begin
          n_state   = SEEK;
          n_locked  = 1'b0;
          n_bit_cnt = '0;
          w_err     = 1'b1;
        end else if (w_lr_edge) begin
          if (r_bit_cnt != CNT_W'(DATA_WIDTH)) begin
            n_state  = SEEK;
            n_locked = 1'b0;
            w_err    = 1'b1;
          end
          n_bit_cnt = '0;
          n_slot_lr = w_lr;
        end else if (w_bclk_rise && r_bit_cnt != CNT_W'(DATA_WIDTH)) begin
          n_shift   = w_word;
          n_bit_cnt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            if (r_slot_lr) begin
              n_r_data = w_word;
              n_r_stb  = 1'b1;
            end else begin
              n_l_data = w_word;
              n_l_stb  = 1'b1;
              n_locked = 1'b1;
            end
          end
        end
      end
      default: n_state = IDLE;
    endcase

    if (!enable) begin
      n_state   = IDLE;
      n_locked  = 1'b0;
      n_bit_cnt = '0;
      n_tmo     = '0;
      n_l_stb   = 1'b0;
      n_r_stb   = 1'b0;
      n_l_data  = l_data;
      n_r_data  = r_data;
      w_err     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_prev_lr  <= 1'b0;
      r_slot_lr  <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tmo      <= '0;
      l_data     <= '0;
      r_data     <= '0;
      l_data_stb <= 1'b0;
      r_data_stb <= 1'b0;
      locked     <= 1'b0;
    end else begin
      r_state    <= n_state;
      r_prev_lr  <= n_prev_lr;
      r_slot_lr  <= n_slot_lr;
      r_bit_cnt  <= n_bit_cnt;
      r_shift    <= n_shift;
      r_tmo      <= n_tmo;
      l_data     <= n_l_data;
      r_data     <= n_r_data;
      l_data_stb <= n_l_stb;
      r_data_stb <= n_r_stb;
      locked     <= n_locked;
    end
  end

`ifdef AUDIO_I2S_RX_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      frame_err <= w_err;
      if (!enable)
        err_count <= 8'd0;
      else if (w_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`else
  logic w_err_unused;
  assign w_err_unused = w_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_deserializer.sv
`default_nettype none
// Self-checking bench: drives I2S frames, predicts strobes from slot rules.
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        reset_n, enable, bclk, lrclk, s_data;
  logic        l_data_stb, r_data_stb, locked;
  logic [23:0] l_data, r_data;
`ifdef AUDIO_I2S_RX_ERR_CNT_EN
  logic        frame_err;
  logic [7:0]  err_count;
`endif

  i2s_rx_deserializer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bclk(bclk),
    .lrclk(lrclk), .s_data(s_data), .l_data_stb(l_data_stb),
    .r_data_stb(r_data_stb), .l_data(l_data), .r_data(r_data),
    .locked(locked)
`ifdef AUDIO_I2S_RX_ERR_CNT_EN
    , .frame_err(frame_err), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ch;
    logic [23:0] data;
    longint      mark;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  longint      clk_count = 0;
  int          half_ns = 40;
  bit          model_sync = 0, prev_ch = 0, prev_short = 0, exp_locked = 0;
  logic [23:0] exp_l = '0, exp_r = '0;

  always @(posedge clk) clk_count <= clk_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Every strobe must match the oldest predicted word, 4 clk after its 24th bit edge.
  always @(negedge clk) begin
    if (l_data_stb === 1'b1 || r_data_stb === 1'b1) begin
      chk("strobe_exclusive", {31'd0, l_data_stb & r_data_stb}, 32'd0);
      chk("strobe_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("strobe_channel", {31'd0, r_data_stb}, {31'd0, e.ch});
        chk("strobe_data", e.ch ? r_data : l_data, e.data);
        chk("strobe_latency", 32'(clk_count - e.mark), 32'd4);
        chk("locked_at_strobe", {31'd0, locked}, 32'd1);
      end
    end
  end

  // act: 0 none, 1 enable drop 50 clk, 2 bclk stall 1100 clk, 3 reset pulse
  task automatic send_slot(input bit ch, input logic [23:0] w, input int nbits,
                           input int act_pos, input int act);
    if (ch != prev_ch) begin
      if (model_sync && prev_short) begin
        model_sync = 0;
        exp_locked = 0;
      end else if (!model_sync && prev_ch && !ch) begin
        model_sync = 1;
      end
    end
    prev_ch    = ch;
    prev_short = (nbits < 25);
    for (int pos = 0; pos < nbits; pos++) begin
      bclk   = 1'b0;
      lrclk  = ch;
      s_data = (pos >= 1 && pos <= 24) ? w[24-pos] : 1'($urandom_range(0, 1));
      if (act == 2 && pos == act_pos) begin
        #(10000 - half_ns);
        chk("locked_before_timeout", {31'd0, locked}, {31'd0, exp_locked});
        model_sync = 0;
        exp_locked = 0;
        #600;
        chk("locked_after_timeout", {31'd0, locked}, {31'd0, exp_locked});
        #400;
      end
      #(half_ns);
      bclk = 1'b1;
      if (act == 1 && pos == act_pos) begin
        model_sync = 0;
        exp_locked = 0;
        fork
          begin enable = 1'b0; #500; enable = 1'b1; end
        join_none
      end
      if (pos == 24 && model_sync) begin
        q.push_back('{ch: ch, data: w, mark: clk_count});
        if (ch) exp_r = w;
        else begin exp_l = w; exp_locked = 1; end
      end
      if (act == 3 && pos == act_pos) begin
        reset_n = 1'b0;
        #2;
        chk("rst_l_data", {8'd0, l_data}, 32'd0);
        chk("rst_r_data", {8'd0, r_data}, 32'd0);
        chk("rst_strobes", {30'd0, l_data_stb, r_data_stb}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        model_sync = 0; exp_locked = 0; exp_l = '0; exp_r = '0;
        #21;
        reset_n = 1'b1;
        #(half_ns - 23);
      end else begin
        #(half_ns);
      end
    end
  endtask

  task automatic send_frame(input logic [23:0] lw, input logic [23:0] rw, input int nbits,
                            input int act_pos, input int act);
    send_slot(1'b0, lw, nbits, act_pos, act);
    send_slot(1'b1, rw, nbits, 0, 0);
    chk("frame_locked", {31'd0, locked}, {31'd0, exp_locked});
    chk("frame_l_data", {8'd0, l_data}, {8'd0, exp_l});
    chk("frame_r_data", {8'd0, r_data}, {8'd0, exp_r});
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; bclk = 1'b0; lrclk = 1'b0; s_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_l_data", {8'd0, l_data}, 32'd0);
    chk("reset_r_data", {8'd0, r_data}, 32'd0);
    chk("reset_strobes", {30'd0, l_data_stb, r_data_stb}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(posedge clk);
    #8;

    // lead-in frame: receiver has no 1->0 transition yet, nothing expected
    send_frame(24'($urandom), 24'($urandom), 32, 0, 0);

    // nominal frames at the slow bit clock
    half_ns = 160;
    send_frame(24'hABCDEF, 24'h123456, 32, 0, 0);
    send_frame(24'hABCDEF, 24'h123456, 32, 0, 0);
    half_ns = 40;

    // reset mid-word, then a full frame is needed before the next strobe
    send_frame(24'($urandom), 24'($urandom), 32, 12, 3);
    send_frame(24'hABCDEF, 24'h123456, 32, 0, 0);

    // bclk stall mid-word, then recovery on the next left slot
    send_frame(24'($urandom), 24'($urandom), 32, 8, 2);
    send_frame(24'hABCDEF, 24'h123456, 32, 0, 0);

    // enable dropped at bit 10 of a left word
    send_frame(24'($urandom), 24'($urandom), 32, 10, 1);
    send_frame(24'($urandom), 24'($urandom), 32, 0, 0);

    // short 16-bit slots never complete a word
    repeat (4) send_frame(24'($urandom), 24'($urandom), 16, 0, 0);
    chk("short_slot_locked", {31'd0, locked}, 32'd0);

    // ramp frames with randomized slot lengths from 25 to 32 bits
    for (int n = 0; n < 64; n++)
      send_frame(24'(n), ~24'(n), 25 + $urandom_range(0, 7), 0, 0);

    for (int k = 0; k < 8; k++)
      send_frame(24'($urandom), 24'($urandom), 32, 0, 0);

    #2000;
    chk("pending_words", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
